// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_pkg
// Brief    : Shared types and crossing-pattern constants for sensor_seq_gen.
// Revision : 1.0 - initial release
// ============================================================================
package sensor_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    // Each entry is {a,b} for PH1..PH3; GAP and IDLE are always 00.
    localparam logic [1:0] ENTRY_PAT [1:3] = '{2'b10, 2'b11, 2'b01};
    localparam logic [1:0] EXIT_PAT  [1:3] = '{2'b01, 2'b11, 2'b10};

    function automatic logic [1:0] pattern(input logic dir, input state_t st);
        logic [1:0] pat;
        pat = 2'b00;
        case (st)
            PH1:     pat = (dir == DIR_EXIT) ? EXIT_PAT[1] : ENTRY_PAT[1];
            PH2:     pat = (dir == DIR_EXIT) ? EXIT_PAT[2] : ENTRY_PAT[2];
            PH3:     pat = (dir == DIR_EXIT) ? EXIT_PAT[3] : ENTRY_PAT[3];
            default: pat = 2'b00;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_seq_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : sensor_seq_gen_if
// Brief    : Request/sensor bundle between a requester and sensor_seq_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface sensor_seq_gen_if;

    logic req_in;
    logic req_out;
    logic a;
    logic b;
    logic busy;
    logic done;

    modport master (
        output req_in,
        output req_out,
        input  a,
        input  b,
        input  busy,
        input  done
    );

    modport slave (
        input  req_in,
        input  req_out,
        output a,
        output b,
        output busy,
        output done
    );

endinterface
`default_nettype wire

// File: rtl/sensor_seq_gen_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : phase_timer
// Brief    : Loadable down-counter that saturates at zero.
// Revision : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int CNT_W = 5
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    output logic                  zero
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/sensor_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : sensor_seq_gen
// Brief    : Emulates a two-sensor crossing (entry/exit) with held phases.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_seq_gen
    import sensor_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  wire logic        clk,
    input  wire logic        reset,
    sensor_seq_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic       dir_q, dir_d;
    logic       a_q, b_q, busy_q, done_q;
    logic [1:0] ab_d;
    logic       busy_d, done_d;
    logic       timer_load, timer_zero;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (LOAD_VAL),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        timer_load = 1'b0;
        case (state_q)
            IDLE: begin
                // req_in has priority; a simultaneous req_out is dropped.
                if (bus.req_in) begin
                    state_d    = PH1;
                    dir_d      = DIR_ENTRY;
                    timer_load = 1'b1;
                end else if (bus.req_out) begin
                    state_d    = PH1;
                    dir_d      = DIR_EXIT;
                    timer_load = 1'b1;
                end
            end
            PH1: if (timer_zero) begin state_d = PH2; timer_load = 1'b1; end
            PH2: if (timer_zero) begin state_d = PH3; timer_load = 1'b1; end
            PH3: if (timer_zero) begin state_d = GAP; timer_load = 1'b1; end
            GAP: if (timer_zero) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ab_d   = pattern(dir_d, state_d);
        busy_d = (state_d != IDLE);
        done_d = (state_q == GAP) && timer_zero;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= DIR_ENTRY;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            a_q     <= ab_d[1];
            b_q     <= ab_d[0];
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.a    = a_q;
    assign bus.b    = b_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_seq_gen
// Brief    : Directed and random checks of sensor_seq_gen against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_seq_gen;

    localparam int H = 4;

    logic clk;
    logic reset;
    sensor_seq_gen_if bus ();

    sensor_seq_gen #(
        .HOLD_CYCLES (H)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_c  = -10000;   // cycle in which the current/last sequence was accepted
    bit mdir     = 1'b0;

    // Per-phase {a,b} for phase index 0..3 (PH1, PH2, PH3, GAP).
    logic [1:0] entry_tab [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] exit_tab  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: check this cycle's outputs, then apply inputs sampled at its end.
    task automatic step(input bit rin, input bit rout, input bit rst);
        int         off;
        logic [1:0] exp_ab;
        logic       exp_busy, exp_done;
        @(negedge clk);
        off      = cyc - start_c;
        exp_busy = (off >= 1) && (off <= 4 * H);
        exp_done = (off == 4 * H + 1);
        exp_ab   = 2'b00;
        if (exp_busy) exp_ab = mdir ? exit_tab[(off - 1) / H] : entry_tab[(off - 1) / H];
        check("a",    bus.a,    exp_ab[1]);
        check("b",    bus.b,    exp_ab[0]);
        check("busy", bus.busy, exp_busy);
        check("done", bus.done, exp_done);

        bus.req_in  = rin;
        bus.req_out = rout;
        reset       = rst;
        if (rst) begin
            start_c = -10000;
            mdir    = 1'b0;
        end else if ((off > 4 * H) && (rin || rout)) begin
            start_c = cyc;
            mdir    = !rin;
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        reset       = 1'b1;
        bus.req_in  = 1'b0;
        bus.req_out = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then a plain entry sequence.
        step(0, 0, 1);
        step(1, 0, 0);
        repeat (20) step(0, 0, 0);

        // Exit sequence.
        step(0, 1, 0);
        repeat (20) step(0, 0, 0);

        // Simultaneous requests: entry wins, exit is not queued.
        step(1, 1, 0);
        repeat (22) step(0, 0, 0);

        // Exit request mid-entry is ignored.
        step(1, 0, 0);
        repeat (5) step(0, 0, 0);
        step(0, 1, 0);
        repeat (14) step(0, 0, 0);

        // Reset mid-sequence, then a fresh sequence.
        step(1, 0, 0);
        repeat (6) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (20) step(0, 0, 0);

        // Level-held request restarts back-to-back on the done cycle.
        step(1, 0, 0);
        repeat (40) step(0, 1, 0);
        repeat (20) step(0, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 6) == 0, ($urandom % 5) == 0, ($urandom % 70) == 0);
        end
        repeat (20) step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
